fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the single-cycle/in-order RISC-V core. It owns the program counter, drives the word address into the combinational instruction memory, and captures each returned instruction, together with its PC, into a small FIFO. The FIFO feeds the decode stage over a valid/ready handshake. Control-flow redirects (branch, jump, trap) flush the FIFO and reload the PC.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2: instruction buffer entries; power of two, ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- imem_addr  output  32  fetch address to instruction memory (byte address, word aligned)
- imem_instr  input  32  instruction returned combinationally for imem_addr in the same cycle
- halt  input  1  when high, no new fetches are issued; the FIFO still drains
- redirect_valid  input  1  one-cycle request to change control flow
- redirect_pc  input  32  target byte address for the redirect
- out_valid  output  1  FIFO head holds a valid instruction
- out_ready  input  1  decode accepts the head this cycle
- out_instr  output  32  head instruction; 0 when empty
- out_pc  output  32  PC of the head instruction; 0 when empty
- misalign  output  1  one-cycle pulse: the accepted redirect_pc had bits [1:0] ≠ 0

## Operation
- Registers:
  - pc (32 b)
  - FIFO storage of {pc, instr} pairs
  - rd_ptr, wr_ptr
  - count (0..FIFO_DEPTH)
  - misalign (registered)
- imem_addr = pc, driven directly from the register with no combinational path from inputs.
- pop = out_valid & out_ready. The head is consumed and rd_ptr advances, wrapping modulo FIFO_DEPTH.
- can_push = !halt & !redirect_valid & (count < FIFO_DEPTH | pop).
- push = can_push. Write {pc, imem_instr} at wr_ptr, advance wr_ptr, and set pc <= pc + 4. The add wraps modulo 2^32; no overflow flag.
- count update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Redirect (priority over everything):
  - FIFO cleared: count=0, rd_ptr=wr_ptr=0.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - misalign <= |redirect_pc[1:0].
  - No push that cycle.
  - A pop occurring in the same cycle still counts as a completed handshake for decode; all remaining entries are discarded.
- misalign is 0 in every cycle that follows a non-redirect cycle.
- halt does not block a redirect. A redirect during halt updates pc and flushes, but issues no fetch until halt drops.
- out_valid = (count != 0). out_instr and out_pc show the head entry, or 0 when count = 0.
- Full FIFO without pop: no push; pc holds; imem_addr stable.
- Reset, asynchronous on rst_n low:
  - pc = RESET_PC
  - count = 0, pointers = 0
  - out_valid = 0, out_instr = 0, out_pc = 0
  - misalign = 0
  - imem_addr = RESET_PC
- Reset mid-operation discards all buffered entries immediately, without waiting for a clock edge.

## Timing
- Fetch-to-output latency is 1 cycle: an instruction pushed at edge N appears on out_* after edge N.
- The first instruction (at RESET_PC) is valid 1 cycle after the first rising edge following rst_n deassertion, provided halt = 0.
- Sustained throughput is 1 instruction/cycle with out_ready held high. count settles at 1.
- Redirect bubble: redirect_valid sampled at edge N.
  - out_valid = 0 after N.
  - The target instruction is fetched at edge N+1 and valid after N+1.
  - Net penalty: 1 cycle with out_valid low.
- Back-pressure:
  - With out_ready = 0, the FIFO fills in FIFO_DEPTH cycles, then pc stalls.
  - When out_ready rises, pop and push proceed in the same cycle, so there is no bubble.
- The handshake is standard valid/ready. out_* stay stable while out_valid & !out_ready, except when a redirect or reset occurs.

## Test plan
- Reset release, RESET_PC = 0, program words 0x00500093, 0x00100113, 0x002081B3, out_ready = 1. Expected:
  - imem_addr steps 0, 4, 8.
  - out_pc/out_instr are (0, 0x00500093), (4, 0x00100113), (8, 0x002081B3) on consecutive cycles.
- Hold out_ready = 0 for 5 cycles from reset. Expected:
  - count saturates at 2.
  - imem_addr holds at 0x8.
  - out_pc holds at 0.
  - After out_ready = 1, entries 0, 4, 8 are delivered with no gap.
- Streaming at pc 0x10, then redirect_valid with redirect_pc = 0x40. Expected:
  - Next cycle: out_valid = 0 and imem_addr = 0x40.
  - Following cycle: out_pc = 0x40.
  - Buffered 0x14 is never emitted.
- redirect_pc = 0x43. Expected: pc loads 0x40, misalign pulses high for exactly 1 cycle, and out_pc = 0x40 two cycles later.
- halt = 1 with 2 buffered entries and out_ready = 1. Expected:
  - Both entries drain, then out_valid = 0.
  - imem_addr is unchanged while halt is high.
  - Deasserting halt resumes fetch at the held pc.
- Assert rst_n low mid-stream (asynchronously, between edges). Expected:
  - out_valid, out_pc, out_instr, and misalign drop to 0 immediately.
  - imem_addr = RESET_PC before the next clock edge.
  - Pc wrap check: redirect to 0xFFFFFFFC is followed by a fetch at 0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the word address into the
// combinational instruction memory and buffers {pc, instr} pairs in a small
// FIFO that feeds decode over a valid/ready handshake. Redirects flush the
// FIFO and reload the PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign
);

  localparam int unsigned     PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = (PTR_W)'(1);
  localparam logic [PTR_W:0]  CNT_ONE = (PTR_W + 1)'(1);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             misalign_q, misalign_d;

  logic [31:0] pc_mem    [FIFO_DEPTH];
  logic [31:0] instr_mem [FIFO_DEPTH];

  logic pop;
  logic push;

  // The fetch address comes straight from the PC register, so imem sees no
  // combinational path from any input.
  assign imem_addr = pc_q;
  assign misalign  = misalign_q;

  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : 32'h0;

  // A full FIFO can still accept a fetch when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = ~halt & ~redirect_valid & ((count_q < DEPTH_C) | pop);

  // Next-state for PC, pointers, occupancy and the misalign pulse.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    misalign_d = 1'b0;

    if (redirect_valid) begin
      // Redirect wins: discard everything buffered, including a head popped this cycle.
      pc_d       = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      misalign_d = |redirect_pc[1:0];
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; reset empties the FIFO immediately via count_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      pc_q       <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // FIFO storage write port.
  // NOTE: storage is deliberately not reset; outputs are masked by count_q, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= pc_q;
      instr_mem[wr_ptr_q] <= imem_instr;
    end
  end

endmodule
